fetch_sequencer: RTL
====================

# fetch_sequencer

Control block for the instruction-fetch stage. It owns the PC, decides each cycle whether the shared single-port instruction memory serves fetch or the program loader, and produces the 64-bit IF_ID pipeline register {pc, instruction} with a valid flag. It sits between the program loader, the instruction memory and the decode stage, and handles decode stalls, branch redirects and a halt instruction.

## Interface
- ADDR_W, 7: instruction-memory word-address width (128 words).
- RESET_PC, 32'h0: PC value loaded on reset and on every restart.
- HALT_INSN, 32'hFFFFFFFF: instruction word that stops fetching.
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- load_valid  in  1  loader write request.
- load_addr  in  ADDR_W  loader word address.
- load_data  in  32  loader write data.
- load_ready  out  1  loader write accepted this cycle (combinational).
- load_done  in  1  single-cycle pulse: program loaded, start fetching from RESET_PC.
- stall  in  1  decode cannot accept; hold IF_ID.
- redirect_valid  in  1  branch taken.
- redirect_pc  in  32  branch target, word address.
- mem_addr  out  ADDR_W  memory address (combinational).
- mem_we  out  1  memory write enable (combinational).
- mem_wdata  out  32  memory write data, equal to load_data.
- mem_rdata  in  32  asynchronous read data for mem_addr.
- IF_ID  out  64  [63:32] fetched pc, [31:0] instruction.
- if_id_valid  out  1  IF_ID holds an instruction not yet consumed.
- pc  out  32  next fetch address.
- halted  out  1  high in HALT state.

## Operation
- FSM states:
  - IDLE: reset state.
  - RUN: fetching.
  - HALT: stopped after fetching HALT_INSN.
- IDLE and HALT:
  - load_ready=1. Loader owns the port.
  - mem_addr=load_addr, mem_we=load_valid.
  - On load_done: pc<=RESET_PC, go to RUN.
- RUN, priority order:
  - redirect_valid: pc<=redirect_pc, if_id_valid<=0, IF_ID held. stall is ignored.
  - Else stall: IF_ID, if_id_valid and pc held. Port is free, so load_ready=1 and loader writes are accepted.
  - Else fetch: mem_addr=pc[ADDR_W-1:0], IF_ID<={pc, mem_rdata}, if_id_valid<=1.
    - If mem_rdata==HALT_INSN: pc is held, go to HALT.
    - Otherwise pc<=pc+1.
- In RUN, load_ready = stall & ~redirect_valid. mem_we = load_valid & load_ready.
- Arithmetic and addressing:
  - pc is a 32-bit word address; pc+1 wraps modulo 2^32.
  - The memory index is pc[ADDR_W-1:0], so fetch wraps from word 127 to word 0.
  - Upper pc bits are carried into IF_ID unchanged.
- HALT:
  - if_id_valid holds while stall=1 and clears on the first cycle with stall=0.
  - halted=1.
  - load_done restarts at RESET_PC.
  - redirect_valid is ignored.
- load_done in RUN is ignored.
- Reset values: state IDLE, pc=RESET_PC, IF_ID=0, if_id_valid=0, halted=0.
  - Combinational outputs after reset: load_ready=1, mem_we=load_valid.
- Reset mid-operation: all state returns to reset values on that edge. A loader write presented in the reset cycle is dropped (mem_we=0 while reset=1).

## Timing
- load_done sampled at edge k: state=RUN after edge k. First fetch is captured at edge k+1, giving IF_ID={RESET_PC, mem[RESET_PC]} and if_id_valid=1.
- Throughput: one instruction per cycle with stall=0.
- Redirect sampled at edge k: one bubble (if_id_valid=0 after edge k). The target instruction is in IF_ID after edge k+1.
- load_valid and load_done in the same IDLE cycle: the write is performed and RUN is entered on the same edge.
- Loader write and fetch never share a cycle; memory is write-first only if the loader writes in a stall cycle.
- A stall released at edge k resumes fetch at the held pc on edge k.

## Test plan
- Reset, load mem[i]=i+100 for i=0..4 and mem[5]=HALT_INSN, pulse load_done -> IF_ID = {0,100},{1,101},…,{5,FFFFFFFF} on consecutive cycles; then halted=1 and pc=5.
- While running at pc=2, hold stall for 3 cycles -> IF_ID stays {1,101}, pc stays 2, load_ready=1. A load_valid to addr 20 in that window writes mem[20].
- Redirect to pc=20 while stall=1 -> stall ignored, one bubble, then IF_ID={20, mem[20]}.
- Redirect to pc=126 with no halt in memory -> IF_ID pc values 126, 127, 128; the 128 fetch reads mem[0].
- In HALT, pulse load_done -> restart at RESET_PC with first IF_ID one cycle later. Assert reset mid-RUN with load_valid=1 -> mem_we=0, all outputs at reset values next cycle.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch control: owns the PC, arbitrates the single-port instruction
// memory between fetch and the program loader, and holds the IF_ID register.
module fetch_sequencer #(
    parameter int          ADDR_W    = 7,
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter logic [31:0] HALT_INSN = 32'hFFFF_FFFF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    output logic              load_ready,
    input  logic              load_done,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [63:0]       IF_ID,
    output logic              if_id_valid,
    output logic [31:0]       pc,
    output logic              halted
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } if_id_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    if_id_t      if_id_q, if_id_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic        loader_owns_port;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            if_id_q       <= '0;
            if_id_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_q       <= if_id_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        if_id_d          = if_id_q;
        if_id_valid_d    = if_id_valid_q;
        loader_owns_port = 1'b1;
        mem_addr         = load_addr;
        case (state_q)
            RUN: begin
                if (redirect_valid) begin
                    // Redirect wins over stall: drop the in-flight slot, keep IF_ID contents.
                    loader_owns_port = 1'b0;
                    mem_addr         = pc_q[ADDR_W-1:0];
                    pc_d             = redirect_pc;
                    if_id_valid_d    = 1'b0;
                end else if (!stall) begin
                    loader_owns_port = 1'b0;
                    mem_addr         = pc_q[ADDR_W-1:0];
                    if_id_d          = '{pc: pc_q, insn: mem_rdata};
                    if_id_valid_d    = 1'b1;
                    if (mem_rdata == HALT_INSN) begin
                        state_d = HALT;
                    end else begin
                        pc_d = pc_q + 32'd1;
                    end
                end
            end
            HALT: begin
                if (!stall) begin
                    if_id_valid_d = 1'b0;
                end
                if (load_done) begin
                    pc_d    = RESET_PC;
                    state_d = RUN;
                end
            end
            default: begin
                if (load_done) begin
                    pc_d    = RESET_PC;
                    state_d = RUN;
                end
            end
        endcase
    end

    // A loader write presented during reset is never accepted.
    assign load_ready  = loader_owns_port & ~reset;
    assign mem_we      = load_valid & load_ready;
    assign mem_wdata   = load_data;
    assign IF_ID       = if_id_q;
    assign if_id_valid = if_id_valid_q;
    assign pc          = pc_q;
    assign halted      = (state_q == HALT);

endmodule
